// File: rtl/lcd_window_writer.sv
// rtl/lcd_window_writer.sv - window command sequencer and pixel forwarder for the LCD SPI serializer
//
// Purpose:
//   Accepts a rectangular window request, writes the CASET/RASET/RAMWR command
//   bytes into the 9-bit command FIFO, waits until the serializer has finished
//   sending them, then forwards exactly width*height pixel words from the
//   upstream valid/ready stream into the pixel FIFO.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 window request strobe (sampled in IDLE only)
//   x0, x1, y0, y1        inclusive window bounds
//   ready                 high while idle
//   done                  one-cycle pulse after the last pixel is written
//   err                   one-cycle pulse when a start is rejected
//   cmd_full, cmd_empty   command FIFO status
//   cmd_wr, cmd_data      command FIFO write port (bit 8 = DC, [7:0] byte)
//   pix_full              pixel FIFO full
//   pix_wr, pix_out       pixel FIFO write port
//   lcd_busy              serializer busy flag
//   pix_valid, pix_data   upstream pixel stream
//   pix_ready             upstream pixel ready

module lcd_window_writer #(
  parameter int COORD_W = 8,
  parameter int CNT_W   = 2*COORD_W+1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] y1,
  output logic               ready,
  output logic               done,
  output logic               err,
  input  logic               cmd_full,
  input  logic               cmd_empty,
  output logic               cmd_wr,
  output logic [8:0]         cmd_data,
  input  logic               pix_full,
  output logic               pix_wr,
  output logic [15:0]        pix_out,
  input  logic               lcd_busy,
  input  logic               pix_valid,
  input  logic [15:0]        pix_data,
  output logic               pix_ready
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_WAIT   = 3'd2,
    S_PIXELS = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd10;

  state_t             state, state_nxt;
  logic [3:0]         idx;
  logic [CNT_W-1:0]   count;
  logic [COORD_W-1:0] bx0, bx1, by0, by1;
  logic               err_q;

  logic               bad_window;
  logic               accept;
  logic [CNT_W-1:0]   width, height;
  logic [15:0]        ex0, ex1, ey0, ey1;

  assign bad_window = (x1 < x0) || (y1 < y0);
  assign accept     = (state == S_IDLE) && start && !bad_window;

  // Widened before subtracting so a full-range span (2^COORD_W) does not wrap.
  assign width  = CNT_W'(x1) - CNT_W'(x0) + CNT_W'(1);
  assign height = CNT_W'(y1) - CNT_W'(y0) + CNT_W'(1);

  // Coordinates go to the panel as 16-bit values, high byte first.
  assign ex0 = 16'(bx0);
  assign ex1 = 16'(bx1);
  assign ey0 = 16'(by0);
  assign ey1 = 16'(by1);

  // Command byte ROM, indexed by the current sequence position.
  always_comb begin
    cmd_data = 9'h000;
    case (idx)
      4'd0:    cmd_data = {1'b0, 8'h2A};
      4'd1:    cmd_data = {1'b1, ex0[15:8]};
      4'd2:    cmd_data = {1'b1, ex0[7:0]};
      4'd3:    cmd_data = {1'b1, ex1[15:8]};
      4'd4:    cmd_data = {1'b1, ex1[7:0]};
      4'd5:    cmd_data = {1'b0, 8'h2B};
      4'd6:    cmd_data = {1'b1, ey0[15:8]};
      4'd7:    cmd_data = {1'b1, ey0[7:0]};
      4'd8:    cmd_data = {1'b1, ey1[15:8]};
      4'd9:    cmd_data = {1'b1, ey1[7:0]};
      4'd10:   cmd_data = {1'b0, 8'h2C};
      default: cmd_data = 9'h000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    cmd_wr    = 1'b0;
    pix_ready = 1'b0;
    pix_wr    = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (accept) begin
          state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        cmd_wr = !cmd_full;
        if (cmd_wr && (idx == LAST_IDX)) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Both conditions together mean RAMWR has fully left the serializer,
        // so a pixel cannot overtake it through the serializer's priority.
        if (cmd_empty && !lcd_busy) begin
          state_nxt = S_PIXELS;
        end
      end
      S_PIXELS: begin
        pix_ready = !pix_full;
        pix_wr    = pix_valid && pix_ready;
        if (pix_wr && (count == CNT_W'(1))) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign pix_out = pix_data;
  assign err     = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      count <= '0;
      bx0   <= '0;
      bx1   <= '0;
      by0   <= '0;
      by1   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= (state == S_IDLE) && start && bad_window;
      if (accept) begin
        bx0   <= x0;
        bx1   <= x1;
        by0   <= y0;
        by1   <= y1;
        idx   <= '0;
        count <= width * height;
      end else begin
        if (cmd_wr) begin
          idx <= idx + 4'd1;
        end
        if (pix_wr) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

endmodule
